// File: rtl/sweep_checker.sv
// Receive-side sweep checker: verifies that qualified samples form the arithmetic
// sweep start, start+step, ... up to the last value <= stop, and reports the result.
module sweep_checker #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     cfg_start,
    input  logic [W-1:0]     cfg_stop,
    input  logic [W-1:0]     cfg_step,
    input  logic             sample_valid,
    input  logic [W-1:0]     sample_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             cfg_err,
    output logic             overrun,
    output logic             err_pulse,
    output logic [W-1:0]     expected,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [W-1:0]     first_err_data
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [W-1:0]     stop_q;
    logic [W-1:0]     step_q;

    logic [W:0]       nxt;
    logic             mismatch;
    logic             last_sample;
    logic             bad_cfg;
    logic [CNT_W-1:0] sample_count_inc;
    logic [CNT_W-1:0] err_count_inc;

    // NOTE: every signal gets a value on every path through this block, so no latch is inferred.
    always_comb begin
        // One extra bit keeps expected+step from wrapping past 2^W-1 and looking in range.
        nxt              = {1'b0, expected} + {1'b0, step_q};
        last_sample      = nxt > {1'b0, stop_q};
        mismatch         = sample_data != expected;
        bad_cfg          = (cfg_step == '0) || (cfg_start > cfg_stop);
        sample_count_inc = (&sample_count) ? sample_count : sample_count + CNT_W'(1);
        err_count_inc    = (&err_count) ? err_count : err_count + CNT_W'(1);
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            stop_q         <= '0;
            step_q         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            cfg_err        <= 1'b0;
            overrun        <= 1'b0;
            err_pulse      <= 1'b0;
            expected       <= '0;
            sample_count   <= '0;
            err_count      <= '0;
            first_err_idx  <= '0;
            first_err_data <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (start) begin
                // Start wins over a coincident sample and aborts any sweep in progress.
                stop_q         <= cfg_stop;
                step_q         <= cfg_step;
                expected       <= cfg_start;
                sample_count   <= '0;
                err_count      <= '0;
                first_err_idx  <= '0;
                first_err_data <= '0;
                overrun        <= 1'b0;
                pass           <= 1'b0;
                if (bad_cfg) begin
                    state   <= DONE;
                    cfg_err <= 1'b1;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end else begin
                    state   <= RUN;
                    cfg_err <= 1'b0;
                    busy    <= 1'b1;
                    done    <= 1'b0;
                end
            end else begin
                case (state)
                    RUN: begin
                        if (sample_valid) begin
                            sample_count <= sample_count_inc;
                            if (mismatch) begin
                                err_count <= err_count_inc;
                                err_pulse <= 1'b1;
                                if (err_count == '0) begin
                                    first_err_idx  <= sample_count;
                                    first_err_data <= sample_data;
                                end
                            end
                            if (last_sample) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                // cfg_err and overrun are always clear while running.
                                pass  <= (err_count == '0) && !mismatch;
                            end else begin
                                expected <= nxt[W-1:0];
                            end
                        end
                    end
                    DONE: begin
                        if (sample_valid) begin
                            overrun <= 1'b1;
                            pass    <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sweep_checker.sv
// Bench for sweep_checker (W=8, CNT_W=8): vector table, directed corner sequences and
// randomized sweeps compared every cycle against a queue-based reference model.
module tb_sweep_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] cfg_start = '0;
    logic [7:0] cfg_stop = '0;
    logic [7:0] cfg_step = '0;
    logic       sample_valid = 1'b0;
    logic [7:0] sample_data = '0;
    logic       busy, done, pass, cfg_err, overrun, err_pulse;
    logic [7:0] expected, sample_count, err_count, first_err_idx, first_err_data;

    int total = 0;
    int bad = 0;

    sweep_checker #(.W(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_step(cfg_step),
        .sample_valid(sample_valid), .sample_data(sample_data),
        .busy(busy), .done(done), .pass(pass), .cfg_err(cfg_err),
        .overrun(overrun), .err_pulse(err_pulse), .expected(expected),
        .sample_count(sample_count), .err_count(err_count),
        .first_err_idx(first_err_idx), .first_err_data(first_err_data)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    // Reference model: the whole sweep is a queue of values still awaited.
    int m_phase;   // 0 idle, 1 running, 2 finished
    int m_q[$];
    int m_last, m_cnt, m_err, m_fidx, m_fdata;
    bit m_cfgerr, m_over, m_pulse;

    task automatic model_update(input bit r, input bit st, input int cs, input int ce,
                                input int cp, input bit sv, input int sd);
        m_pulse = 0;
        if (r) begin
            m_phase = 0; m_q.delete(); m_last = 0; m_cnt = 0; m_err = 0;
            m_fidx = 0; m_fdata = 0; m_cfgerr = 0; m_over = 0;
        end else if (st) begin
            m_q.delete(); m_last = cs; m_cnt = 0; m_err = 0;
            m_fidx = 0; m_fdata = 0; m_over = 0;
            if (cp == 0 || cs > ce) begin
                m_phase = 2; m_cfgerr = 1;
            end else begin
                m_phase = 1; m_cfgerr = 0;
                for (int v = cs; v <= ce; v += cp) m_q.push_back(v);
            end
        end else if (m_phase == 1 && sv) begin
            if (sd != m_q[0]) begin
                m_pulse = 1;
                if (m_err == 0) begin m_fidx = m_cnt; m_fdata = sd; end
                m_err = (m_err < 255) ? m_err + 1 : 255;
            end
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_phase = 2;
            else m_last = m_q[0];
        end else if (m_phase == 2 && sv) begin
            m_over = 1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("busy", 32'(busy), 32'(m_phase == 1));
        check("done", 32'(done), 32'(m_phase == 2));
        check("pass", 32'(pass), 32'(m_phase == 2 && m_err == 0 && !m_over && !m_cfgerr));
        check("cfg_err", 32'(cfg_err), 32'(m_cfgerr));
        check("overrun", 32'(overrun), 32'(m_over));
        check("err_pulse", 32'(err_pulse), 32'(m_pulse));
        check("expected", 32'(expected), m_last);
        check("sample_count", 32'(sample_count), m_cnt);
        check("err_count", 32'(err_count), m_err);
        check("first_err_idx", 32'(first_err_idx), m_fidx);
        check("first_err_data", 32'(first_err_data), m_fdata);
    endtask

    task automatic drive(input bit r, input bit st, input int cs, input int ce, input int cp,
                         input bit sv, input int sd);
        @(negedge clk);
        rst = r; start = st;
        cfg_start = cs[7:0]; cfg_stop = ce[7:0]; cfg_step = cp[7:0];
        sample_valid = sv; sample_data = sd[7:0];
        @(posedge clk);
        model_update(r, st, cs, ce, cp, sv, sd);
        #1;
        compare_all();
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic sample(input int sd);
        drive(0, 0, 0, 0, 0, 1, sd);
    endtask

    typedef struct {
        bit st;
        int cs, ce, cp;
        bit sv;
        int sd;
        bit e_busy, e_done, e_pass, e_pulse;
        int e_cnt, e_err, e_exp;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl[NV];

    initial begin
        // st  cs   ce   cp  sv  sd   busy done pass pulse cnt err exp
        tbl[0]  = '{1,   3,  20,  5, 0,   0,  1, 0, 0, 0, 0, 0,   3};
        tbl[1]  = '{0,   0,   0,  0, 1,   3,  1, 0, 0, 0, 1, 0,   8};
        tbl[2]  = '{0,   0,   0,  0, 1,   8,  1, 0, 0, 0, 2, 0,  13};
        tbl[3]  = '{0,   0,   0,  0, 1,   9,  1, 0, 0, 1, 3, 1,  18};
        tbl[4]  = '{0,   0,   0,  0, 0,   0,  1, 0, 0, 0, 3, 1,  18};
        tbl[5]  = '{0,   0,   0,  0, 1,  18,  0, 1, 0, 0, 4, 1,  18};
        tbl[6]  = '{1, 250, 255,  4, 0,   0,  1, 0, 0, 0, 0, 0, 250};
        tbl[7]  = '{0,   0,   0,  0, 1, 250,  1, 0, 0, 0, 1, 0, 254};
        tbl[8]  = '{0,   0,   0,  0, 1, 254,  0, 1, 1, 0, 2, 0, 254};
        tbl[9]  = '{0,   0,   0,  0, 1,   7,  0, 1, 0, 0, 2, 0, 254};
        tbl[10] = '{1,   5,  10,  0, 0,   0,  0, 1, 0, 0, 0, 0,   5};
        tbl[11] = '{1,   9,   5,  1, 0,   0,  0, 1, 0, 0, 0, 0,   9};
        tbl[12] = '{0,   0,   0,  0, 1,   9,  0, 1, 0, 0, 0, 0,   9};
        tbl[13] = '{1,   0,  20,  4, 0,   0,  1, 0, 0, 0, 0, 0,   0};
        tbl[14] = '{0,   0,   0,  0, 1,   0,  1, 0, 0, 0, 1, 0,   4};
        tbl[15] = '{0,   0,   0,  0, 1,   4,  1, 0, 0, 0, 2, 0,   8};
        tbl[16] = '{0,   0,   0,  0, 1,   8,  1, 0, 0, 0, 3, 0,  12};
        tbl[17] = '{1, 100, 102,  1, 1,  12,  1, 0, 0, 0, 0, 0, 100};
        tbl[18] = '{0,   0,   0,  0, 1, 100,  1, 0, 0, 0, 1, 0, 101};
        tbl[19] = '{0,   0,   0,  0, 1, 101,  1, 0, 0, 0, 2, 0, 102};
        tbl[20] = '{0,   0,   0,  0, 1, 102,  0, 1, 1, 0, 3, 0, 102};
        tbl[21] = '{1,   0,  10,  4, 0,   0,  1, 0, 0, 0, 0, 0,   0};
        tbl[22] = '{0,   0,   0,  0, 1,   0,  1, 0, 0, 0, 1, 0,   4};
        tbl[23] = '{0,   0,   0,  0, 1,   4,  1, 0, 0, 0, 2, 0,   8};
        tbl[24] = '{0,   0,   0,  0, 1,   8,  0, 1, 1, 0, 3, 0,   8};

        // Reset state.
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 5);
        check("reset_done", 32'(done), 0);
        check("reset_expected", 32'(expected), 0);
        idle();
        sample(0);
        check("idle_ignores_sample", 32'(sample_count), 0);

        // Vector table.
        for (int i = 0; i < NV; i++) begin
            drive(0, tbl[i].st, tbl[i].cs, tbl[i].ce, tbl[i].cp, tbl[i].sv, tbl[i].sd);
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            check($sformatf("vec%0d_done", i), 32'(done), 32'(tbl[i].e_done));
            check($sformatf("vec%0d_pass", i), 32'(pass), 32'(tbl[i].e_pass));
            check($sformatf("vec%0d_err_pulse", i), 32'(err_pulse), 32'(tbl[i].e_pulse));
            check($sformatf("vec%0d_sample_count", i), 32'(sample_count), tbl[i].e_cnt);
            check($sformatf("vec%0d_err_count", i), 32'(err_count), tbl[i].e_err);
            check($sformatf("vec%0d_expected", i), 32'(expected), tbl[i].e_exp);
            if (i == 5) begin
                check("first_err_idx_sweep2", 32'(first_err_idx), 2);
                check("first_err_data_sweep2", 32'(first_err_data), 9);
            end
            if (i == 9) check("overrun_after_done", 32'(overrun), 1);
            if (i == 11) check("cfg_err_start_gt_stop", 32'(cfg_err), 1);
        end

        // Full 0..15 sweep with an idle cycle between samples.
        drive(0, 1, 0, 15, 1, 0, 0);
        for (int v = 0; v < 16; v++) begin
            sample(v);
            if (v < 15) begin
                idle();
                check("full_sweep_not_done", 32'(done), 0);
            end
        end
        check("full_sweep_done", 32'(done), 1);
        check("full_sweep_pass", 32'(pass), 1);
        check("full_sweep_count", 32'(sample_count), 16);

        // Reset in the middle of a sweep that already has two errors.
        drive(0, 1, 0, 50, 5, 0, 0);
        sample(0); sample(99); sample(10); sample(77);
        check("pre_reset_err_count", 32'(err_count), 2);
        drive(1, 0, 0, 0, 0, 1, 15);
        check("mid_reset_busy", 32'(busy), 0);
        check("mid_reset_err_count", 32'(err_count), 0);
        check("mid_reset_first_err_data", 32'(first_err_data), 0);
        idle();
        drive(0, 1, 1, 3, 1, 0, 0);
        sample(1); sample(2); sample(3);
        check("post_reset_pass", 32'(pass), 1);

        // Counter saturation: 256 samples, every one wrong.
        drive(0, 1, 0, 255, 1, 0, 0);
        for (int v = 0; v < 256; v++) sample(v ^ 8'hff);
        check("sat_sample_count", 32'(sample_count), 255);
        check("sat_err_count", 32'(err_count), 255);
        check("sat_first_err_data", 32'(first_err_data), 255);
        check("sat_done", 32'(done), 1);

        // Randomized sweeps with config noise, aborts and resets.
        for (int s = 0; s < 60; s++) begin
            int cs, ce, cp, n;
            cs = $urandom_range(0, 255);
            cp = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 40);
            ce = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255)
                                              : cs + $urandom_range(0, 80);
            if (ce > 255) ce = 255;
            drive(0, 1, cs, ce, cp, $urandom_range(0, 1), $urandom_range(0, 255));
            n = $urandom_range(5, 40);
            for (int c = 0; c < n; c++) begin
                int sd;
                bit sv, r, st;
                sv = ($urandom_range(0, 2) != 0);
                if (m_q.size() > 0 && $urandom_range(0, 7) != 0) sd = m_q[0];
                else sd = $urandom_range(0, 255);
                r  = ($urandom_range(0, 49) == 0);
                st = ($urandom_range(0, 39) == 0);
                cs = $urandom_range(0, 255);
                ce = $urandom_range(0, 255);
                cp = $urandom_range(0, 8);
                drive(r, st, cs, ce, cp, sv, sd);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
